// File: rtl/lif_neuron.sv
//------------------------------------------------------------------------------
// lif_neuron
//
// Leaky integrate-and-fire neuron with an 8-bit membrane potential.
//
// Each enabled INTEGRATE cycle leaks the membrane by v >> LEAK_SHIFT, then
// adds or subtracts one synaptic weight. The result saturates to 0..255.
// Reaching THRESHOLD fires a one-cycle spike and clears the membrane.
// The neuron then enters REFRACTORY for REFRACT_CYCLES enabled cycles,
// counted from the spike cycle, and ignores all synaptic input meanwhile.
//
// Parameters:
//   THRESHOLD      - firing threshold, 8-bit unsigned (0 fires every cycle)
//   LEAK_SHIFT     - leak divisor exponent 0..7 (0 disables leak)
//   REFRACT_CYCLES - refractory length in enabled cycles, 0..15
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous active-high reset, overrides everything
//   enable      in   low freezes all state and suppresses spike
//   syn_spike   in   synaptic event present this cycle
//   syn_weight  in   [7:0] unsigned weight, used only with syn_spike
//   syn_inhib   in   1 = subtract weight, 0 = add weight
//   spike       out  registered one-cycle fire pulse
//   membrane    out  [7:0] registered membrane potential
//   refractory  out  high while in REFRACTORY (inputs ignored)
//   spike_count out  [15:0] saturating fire counter, present only when
//                    LIF_SPIKE_COUNT_EN is defined
//
// Optional build macro: LIF_SPIKE_COUNT_EN
//------------------------------------------------------------------------------
module lif_neuron #(
   parameter logic [7:0]  THRESHOLD      = 8'd200,
   parameter int unsigned LEAK_SHIFT     = 3,
   parameter int unsigned REFRACT_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        syn_spike,
   input  logic [7:0]  syn_weight,
   input  logic        syn_inhib,
   output logic        spike,
   output logic [7:0]  membrane,
   output logic        refractory
`ifdef LIF_SPIKE_COUNT_EN
   ,
   output logic [15:0] spike_count
`endif
);

   typedef enum logic {
      ST_INTEGRATE  = 1'b0,
      ST_REFRACTORY = 1'b1
   } state_t;

   localparam logic [3:0] REFRACT_LOAD = 4'(REFRACT_CYCLES);
   localparam bit         HAS_REFRACT  = (REFRACT_CYCLES != 0);

   state_t            r_state, w_state_next;
   logic [3:0]        r_count, w_count_next;
   logic [7:0]        r_membrane, w_membrane_next;
   logic              r_spike, w_spike_next;

   logic [7:0]        w_leak;
   logic [7:0]        w_weight;
   logic signed [9:0] w_sum;
   logic [7:0]        w_sat;

   //---------------------------------------------------------------------------
   // Datapath: leak, synaptic update, saturation.
   // A 10-bit signed sum covers -255..510 without overflow.
   //---------------------------------------------------------------------------
   always_comb begin
      w_weight = syn_spike ? syn_weight : 8'd0;

      // A shift of 0 would subtract the whole membrane, so it means "no leak".
      if (LEAK_SHIFT == 0) begin
         w_leak = r_membrane;
      end else begin
         w_leak = r_membrane - (r_membrane >> LEAK_SHIFT);
      end

      if (syn_inhib) begin
         w_sum = $signed({2'b00, w_leak}) - $signed({2'b00, w_weight});
      end else begin
         w_sum = $signed({2'b00, w_leak}) + $signed({2'b00, w_weight});
      end

      if (w_sum < 10'sd0) begin
         w_sat = 8'd0;
      end else if (w_sum > 10'sd255) begin
         w_sat = 8'd255;
      end else begin
         w_sat = w_sum[7:0];
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and next-output logic.
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      w_state_next    = r_state;
      w_count_next    = r_count;
      w_membrane_next = r_membrane;
      w_spike_next    = 1'b0;

      if (enable) begin
         case (r_state)
            ST_INTEGRATE: begin
               if (w_sat >= THRESHOLD) begin
                  w_spike_next    = 1'b1;
                  w_membrane_next = 8'd0;
                  w_count_next    = REFRACT_LOAD;
                  // With no refractory period the spike cycle integrates.
                  if (HAS_REFRACT) begin
                     w_state_next = ST_REFRACTORY;
                  end
               end else begin
                  w_membrane_next = w_sat;
               end
            end

            ST_REFRACTORY: begin
               // Synaptic inputs and leak are ignored; only the counter moves.
               w_membrane_next = 8'd0;
               w_count_next    = (r_count == 4'd0) ? 4'd0 : r_count - 4'd1;
               // The counter value covers the current cycle, so leaving on the
               // 1 -> 0 edge yields exactly REFRACT_CYCLES refractory cycles.
               if (r_count <= 4'd1) begin
                  w_state_next = ST_INTEGRATE;
               end
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // State registers.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_state    <= ST_INTEGRATE;
         r_count    <= 4'd0;
         r_membrane <= 8'd0;
         r_spike    <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_count    <= w_count_next;
         r_membrane <= w_membrane_next;
         r_spike    <= w_spike_next;
      end
   end

   assign spike      = r_spike;
   assign membrane   = r_membrane;
   assign refractory = (r_state == ST_REFRACTORY);

`ifdef LIF_SPIKE_COUNT_EN
   logic [15:0] r_spike_count;

   // Counts edges that set spike; holds at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_spike_count <= 16'd0;
      end else if (w_spike_next && (r_spike_count != 16'hFFFF)) begin
         r_spike_count <= r_spike_count + 16'd1;
      end
   end

   assign spike_count = r_spike_count;
`endif

endmodule

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 SHALL have parameter THRESHOLD, default 200: firing threshold, 8-bit unsigned.
REQ-002 SHALL have parameter LEAK_SHIFT, default 3: leak divisor exponent; legal range 0..7; 0 disables leak.
REQ-003 SHALL have parameter REFRACT_CYCLES, default 4: refractory length in enabled cycles; legal range 0..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: when low, all state holds.
REQ-007 SHALL have port syn_spike, input, 1 bit: synaptic event present this cycle.
REQ-008 SHALL have port syn_weight, input, 8 bits: unsigned synaptic weight; sampled only with syn_spike.
REQ-009 SHALL have port syn_inhib, input, 1 bit: 1 means subtract weight, 0 means add weight.
REQ-010 SHALL have port spike, output, 1 bit: registered one-cycle fire pulse that feeds the downstream synapse.
REQ-011 SHALL have port membrane, output, 8 bits: registered membrane potential.
REQ-012 SHALL have port refractory, output, 1 bit: high while inputs are being ignored.

Function
REQ-013 SHALL implement two states: INTEGRATE and REFRACTORY.
REQ-014 In INTEGRATE with enable=1, SHALL compute leak: v_leak = v - (v >> LEAK_SHIFT), with v_leak = v when LEAK_SHIFT=0.
REQ-015 SHALL compute v_next = v_leak + w (syn_inhib=0) or v_leak - w (syn_inhib=1), where w = syn_weight when syn_spike=1, else 0.
REQ-016 SHALL use at least 10-bit signed intermediate arithmetic, saturating v_next to 0..255.
REQ-017 If saturated v_next < THRESHOLD, SHALL set membrane <= v_next and spike <= 0.
REQ-018 If saturated v_next >= THRESHOLD, SHALL on the same edge set spike <= 1, membrane <= 0, and counter <= REFRACT_CYCLES, and enter REFRACTORY (or stay in INTEGRATE if REFRACT_CYCLES=0).
REQ-019 Latency SHALL be one cycle: an input on the cycle that crosses threshold produces spike=1 on the next cycle.
REQ-020 spike SHALL be high for exactly one cycle per firing.
REQ-021 REFRACTORY SHALL ignore syn_* inputs, hold membrane at 0, apply no leak, and decrement the counter each enabled cycle.
REQ-022 SHALL return to INTEGRATE on the edge where the counter reaches 0.
REQ-023 refractory SHALL be 1 exactly while in REFRACTORY, which covers REFRACT_CYCLES enabled cycles starting with the spike cycle.
REQ-024 With REFRACT_CYCLES=0, integration SHALL resume in the spike cycle from membrane=0.
REQ-025 With enable=0, SHALL hold membrane, state and counter, force spike <= 0, and not count the cycle toward refractory.
REQ-026 THRESHOLD=0 SHALL fire on every enabled INTEGRATE cycle (legal, no special case).

Reset
REQ-027 reset SHALL take priority over enable and all inputs.
REQ-028 On reset, SHALL set state = INTEGRATE, membrane = 0, spike = 0, refractory = 0, and counter = 0.
REQ-029 Reset asserted mid-REFRACTORY SHALL abort it, and the first post-reset enabled cycle SHALL integrate.

Configuration
REQ-030 Macro LIF_SPIKE_COUNT_EN defined: SHALL add output spike_count[15:0], reset to 0, incremented on each edge that sets spike <= 1, saturating at 16'hFFFF.
REQ-031 Macro LIF_SPIKE_COUNT_EN undefined: SHALL have no spike_count port and no counter logic; all other behaviour identical.

Verification (defaults THRESHOLD=200, LEAK_SHIFT=3, REFRACT_CYCLES=4)
REQ-032 Reset held 2 cycles, then released with idle inputs -> membrane=0, spike=0, refractory=0.
REQ-033 One excitatory weight 100, then idle -> membrane 100, 88, 77, 68 on successive cycles; no spike.
REQ-034 Excitatory 150 on two consecutive cycles -> membrane 150, then saturated 255 >= 200 -> next cycle spike=1 and membrane=0; refractory=1 for 4 cycles; spike_count=1 if LIF_SPIKE_COUNT_EN.
REQ-035 Weight 255 applied every cycle during refractory -> membrane stays 0 and no spike; first integrate cycle after refractory loads 255 and fires again.
REQ-036 membrane=30, inhibitory weight 50 -> membrane=0 (floor saturation); enable=0 for 3 cycles mid-refractory -> counter and membrane frozen, refractory extended by 3 cycles.
REQ-037 reset asserted in 2nd refractory cycle together with syn_spike=1 -> membrane=0, refractory=0, spike=0; the next cycle integrates normally.
